// File: rtl/dds_cmd_engine.sv
// Command-driven DDS engine: decodes SPI command words into double-buffered
// tuning/phase/waveform registers, runs the phase accumulator and drives the DAC.
module dds_cmd_engine #(
  parameter int DAC_W = 12,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [31:0]      cmd_data,
  output logic             cmd_ack,
  input  logic             rsp_free,
  output logic             rsp_wr_en,
  output logic [23:0]      rsp_data,
  output logic [DAC_W-1:0] dac_data,
  output logic             dac_valid,
  output logic             sync_pulse
);

  localparam logic [7:0] OP_FTW_LO = 8'h10;
  localparam logic [7:0] OP_FTW_HI = 8'h11;
  localparam logic [7:0] OP_PHASE  = 8'h12;
  localparam logic [7:0] OP_CTRL   = 8'h13;
  localparam logic [7:0] OP_APPLY  = 8'h14;
  localparam logic [7:0] OP_RD_FTW = 8'h15;
  localparam logic [7:0] OP_RD_ST  = 8'h16;

  localparam logic [1:0] W_SAW = 2'd0;
  localparam logic [1:0] W_TRI = 2'd1;
  localparam logic [1:0] W_SQR = 2'd2;

  typedef enum logic [1:0] {IDLE, DECODE, RESP} state_t;

  state_t state, state_nx;

  logic             valid_q, valid_q2, pend;
  logic             valid_rise, take;
  logic [31:0]      cmd_q;
  logic [7:0]       op;
  logic [23:0]      p;
  logic             is_rd, apply_clr;

  logic [ACC_W-1:0] shadow_ftw, active_ftw;
  logic [15:0]      shadow_pow, active_pow;
  logic [1:0]       shadow_wave, active_wave;
  logic             shadow_en, active_en;
  logic             pending;

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_sum;
  logic [15:0]      phase, tri_base;
  logic [DAC_W-1:0] sample;

  // Command acceptance: edge of the registered cmd_valid, remembered one-deep
  // while busy so a word arriving during DECODE/RESP is taken on return to IDLE.
  assign valid_rise = valid_q & ~valid_q2;
  assign take       = valid_rise | pend;
  assign op         = cmd_q[7:0];
  assign p          = cmd_q[31:8];
  assign is_rd      = (op == OP_RD_FTW) || (op == OP_RD_ST);
  assign apply_clr  = (state == DECODE) && (op == OP_APPLY) && p[0];
  assign pending    = {shadow_ftw, shadow_pow, shadow_wave, shadow_en} !=
                      {active_ftw, active_pow, active_wave, active_en};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      valid_q  <= 1'b0;
      valid_q2 <= 1'b0;
      pend     <= 1'b0;
      cmd_q    <= '0;
    end else begin
      state    <= state_nx;
      valid_q  <= cmd_valid;
      valid_q2 <= valid_q;
      if (cmd_ack)         pend <= 1'b0;
      else if (valid_rise) pend <= 1'b1;
      if (cmd_ack) cmd_q <= cmd_data;
    end
  end

  always_comb begin
    state_nx  = state;
    cmd_ack   = 1'b0;
    rsp_wr_en = 1'b0;
    case (state)
      IDLE: if (take) begin
        cmd_ack  = 1'b1;
        state_nx = DECODE;
      end
      DECODE: state_nx = is_rd ? RESP : IDLE;
      RESP: if (rsp_free) begin
        rsp_wr_en = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_ftw  <= '0;
      shadow_pow  <= '0;
      shadow_wave <= W_SAW;
      shadow_en   <= 1'b0;
      active_ftw  <= '0;
      active_pow  <= '0;
      active_wave <= W_SAW;
      active_en   <= 1'b0;
      rsp_data    <= '0;
    end else if (state == DECODE) begin
      case (op)
        OP_FTW_LO: shadow_ftw[23:0]  <= p;
        OP_FTW_HI: shadow_ftw[31:24] <= p[7:0];
        OP_PHASE:  shadow_pow        <= p[15:0];
        OP_CTRL: begin
          shadow_wave <= p[1:0];
          shadow_en   <= p[8];
        end
        OP_APPLY: begin
          active_ftw  <= shadow_ftw;
          active_pow  <= shadow_pow;
          active_wave <= shadow_wave;
          active_en   <= shadow_en;
        end
        OP_RD_FTW: rsp_data <= active_ftw[23:0];
        OP_RD_ST:  rsp_data <= {active_ftw[31:24], 8'h00, 4'h0,
                                pending, active_en, active_wave};
        default: ;
      endcase
    end
  end

  // Sample generation; tri_base shifts left so the TRI slice stays in range at DAC_W=16.
  assign acc_sum  = {1'b0, acc} + {1'b0, active_ftw};
  assign phase    = acc[ACC_W-1 -: 16] + active_pow;
  assign tri_base = {phase[14:0], 1'b0};

  always_comb begin
    sample = '0;
    case (active_wave)
      W_SAW:   sample = phase[15 -: DAC_W];
      W_TRI:   sample = phase[15] ? ~tri_base[15 -: DAC_W] : tri_base[15 -: DAC_W];
      W_SQR:   sample = phase[15] ? '1 : '0;
      default: sample = active_pow[15 -: DAC_W];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      sync_pulse <= 1'b0;
      dac_data   <= '0;
      dac_valid  <= 1'b0;
    end else begin
      if (apply_clr) begin
        acc        <= '0;
        sync_pulse <= 1'b0;
      end else if (active_en) begin
        acc        <= acc_sum[ACC_W-1:0];
        sync_pulse <= acc_sum[ACC_W];
      end else begin
        sync_pulse <= 1'b0;
      end
      dac_data  <= sample;
      dac_valid <= active_en;
    end
  end

endmodule

// File: tb/tb_dds_cmd_engine.sv
// Directed bench for dds_cmd_engine: command handshake, DDS output patterns,
// readback with back-pressure, apply/clear and unknown opcodes.
module tb_dds_cmd_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ack;
  logic        rsp_free = 1'b1;
  logic        rsp_wr_en;
  logic [23:0] rsp_data;
  logic [11:0] dac_data;
  logic        dac_valid;
  logic        sync_pulse;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int wr_cnt = 0;
  logic [23:0] last_rsp = '0;

  dds_cmd_engine #(.DAC_W(12), .ACC_W(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ack(cmd_ack),
    .rsp_free(rsp_free), .rsp_wr_en(rsp_wr_en), .rsp_data(rsp_data),
    .dac_data(dac_data), .dac_valid(dac_valid), .sync_pulse(sync_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_ack) ack_cnt++;
    if (rsp_wr_en) begin
      wr_cnt++;
      last_rsp = rsp_data;
    end
  end

  // Present one word and wait (bounded) for its ack; returns on the ack negedge.
  task automatic send(input logic [31:0] w);
    bit got = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = w;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_ack) begin
        got = 1;
        break;
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL send_ack word=%h got no ack, required ack", w);
    end
  endtask

  task automatic test_reset;
    bit bad = 0;
    bit saw_sync = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmd_ack || rsp_wr_en || rsp_data != 0 || dac_data != 0 || dac_valid) bad = 1;
      if (sync_pulse) saw_sync = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_outputs some output nonzero, required all 0");
    end
    checks++;
    if (dut.acc !== 32'h0) begin
      errors++;
      $display("FAIL reset_acc got %h required 0", dut.acc);
    end
    checks++;
    if (saw_sync) begin
      errors++;
      $display("FAIL reset_sync got pulse required none");
    end
  endtask

  task automatic test_saw;
    int a0 = ack_cnt;
    logic [11:0] exp;
    send(32'h0000_0010);
    send(32'h0000_4011);
    send(32'h0001_0013);
    send(32'h0000_0014);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      exp = 12'((k % 4) * 12'h400);
      checks++;
      if (dac_data !== exp || dac_valid !== 1'b1) begin
        errors++;
        $display("FAIL saw_dac k=%0d got %h/%b required %h/1", k, dac_data, dac_valid, exp);
      end
      checks++;
      if (sync_pulse !== (k % 4 == 3)) begin
        errors++;
        $display("FAIL saw_sync k=%0d got %b required %b", k, sync_pulse, (k % 4 == 3));
      end
    end
    checks++;
    if (ack_cnt != a0 + 4) begin
      errors++;
      $display("FAIL saw_ack_count got %0d required %0d", ack_cnt - a0, 4);
    end
  endtask

  task automatic test_backpressure;
    int w0;
    bit early_wr = 0;
    bit early_ack = 0;
    send(32'h3456_7810);
    send(32'h0000_1211);
    send(32'h0000_0014);
    rsp_free = 1'b0;
    w0 = wr_cnt;
    send(32'h0000_0015);
    repeat (5) begin
      @(negedge clk);
      if (rsp_wr_en) early_wr = 1;
    end
    cmd_valid = 1'b1;
    cmd_data  = 32'h0000_0012;
    repeat (6) begin
      @(negedge clk);
      if (cmd_ack) early_ack = 1;
      if (rsp_wr_en) early_wr = 1;
    end
    checks++;
    if (early_wr || wr_cnt != w0) begin
      errors++;
      $display("FAIL bp_no_wr got wr while rsp_free=0, required none");
    end
    checks++;
    if (early_ack) begin
      errors++;
      $display("FAIL bp_second_ack got ack during RESP, required none");
    end
    rsp_free = 1'b1;
    #1;
    checks++;
    if (rsp_wr_en !== 1'b1 || rsp_data !== 24'h345678) begin
      errors++;
      $display("FAIL bp_rsp got wr=%b data=%h required 1/345678", rsp_wr_en, rsp_data);
    end
    @(negedge clk);
    checks++;
    if (cmd_ack !== 1'b1 || rsp_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_taken got ack=%b wr=%b required 1/0", cmd_ack, rsp_wr_en);
    end
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_cnt != w0 + 1) begin
      errors++;
      $display("FAIL bp_wr_count got %0d required 1", wr_cnt - w0);
    end
  endtask

  task automatic test_apply_clear;
    send(32'h0000_0010);
    send(32'h0000_4011);
    send(32'h0000_0114);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dut.acc !== 32'h0) begin
      errors++;
      $display("FAIL clr_acc got %h required 0", dut.acc);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (dac_data !== 12'(k * 12'h400)) begin
        errors++;
        $display("FAIL clr_dac k=%0d got %h required %h", k, dac_data, 12'(k * 12'h400));
      end
    end
  endtask

  task automatic test_sqr_pending;
    logic [11:0] prev;
    bit bad = 0;
    int w0;
    int ones = 0;
    send(32'h0001_0213);
    @(negedge clk);
    prev = dac_data;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (dac_data !== prev + 12'h400) bad = 1;
      prev = dac_data;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL sqr_shadow_only output changed before APPLY, required SAW steps");
    end
    w0 = wr_cnt;
    send(32'h0000_0016);
    repeat (4) @(negedge clk);
    checks++;
    if (wr_cnt != w0 + 1 || last_rsp !== 24'h40000C) begin
      errors++;
      $display("FAIL status_pending got %h n=%0d required 40000c n=1", last_rsp, wr_cnt - w0);
    end
    send(32'h0000_0014);
    send(32'h0000_0016);
    repeat (4) @(negedge clk);
    checks++;
    if (last_rsp !== 24'h400006) begin
      errors++;
      $display("FAIL status_applied got %h required 400006", last_rsp);
    end
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (dac_data == 12'hFFF) ones++;
      else if (dac_data != 12'h000) bad = 1;
    end
    checks++;
    if (bad || ones != 4) begin
      errors++;
      $display("FAIL sqr_dac got %0d highs bad=%b required 4 highs of 0/fff", ones, bad);
    end
  endtask

  task automatic test_unknown;
    int a0 = ack_cnt;
    int w0 = wr_cnt;
    logic [31:0] sh  = dut.shadow_ftw;
    logic [31:0] act = dut.active_ftw;
    send(32'hABCD_EF03);
    send(32'h1234_567F);
    repeat (4) @(negedge clk);
    checks++;
    if (ack_cnt != a0 + 2 || wr_cnt != w0) begin
      errors++;
      $display("FAIL unknown_ack got acks=%0d wr=%0d required 2/0", ack_cnt - a0, wr_cnt - w0);
    end
    checks++;
    if (dut.shadow_ftw !== sh || dut.active_ftw !== act || dut.pending !== 1'b0) begin
      errors++;
      $display("FAIL unknown_state got %h/%h required %h/%h", dut.shadow_ftw, dut.active_ftw, sh, act);
    end
  endtask

  task automatic test_reset_mid_resp;
    int w0;
    rsp_free = 1'b0;
    send(32'h0000_0015);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    w0 = wr_cnt;
    rsp_free = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_cnt != w0 || dac_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_resp got wr=%0d valid=%b required 0/0", wr_cnt - w0, dac_valid);
    end
  endtask

  initial begin
    test_reset;
    test_saw;
    test_backpressure;
    test_apply_clear;
    test_sqr_pending;
    test_unknown;
    test_reset_mid_resp;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_cmd_engine.md
Name: dds_cmd_engine

Overview:
- Downstream consumer of the SPI command stream: takes 32-bit command words (opcode in bits [7:0], 24-bit payload in bits [31:8]) from the SPI slave receive interface.
- Programs a double-buffered DDS core (frequency tuning word, phase offset, waveform, enable) and drives a parallel DAC sample bus.
- Returns readback words through the SPI slave transmit interface.
- Opcodes 0x10–0x16 are owned by this block; the existing 0x00–0x07 command set is unaffected.

Parameters:
- DAC_W, 12, DAC sample width (4..16).
- ACC_W, 32, phase accumulator / tuning word width (fixed 32; other values unsupported).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  receive word available (level; held until acked)
- cmd_data  in  32  received command word
- cmd_ack  out  1  one-cycle pulse: word consumed
- rsp_free  in  1  SPI transmit buffer free
- rsp_wr_en  out  1  one-cycle pulse: load rsp_data into transmit buffer
- rsp_data  out  24  readback payload
- dac_data  out  DAC_W  DAC sample
- dac_valid  out  1  high every cycle the core is enabled
- sync_pulse  out  1  one-cycle pulse on accumulator wrap (carry out)

Behaviour:
- Reset (async assert, sync release): all outputs 0; accumulator 0; shadow and active registers 0 (ftw=0, pow=0, wave=SAW, en=0); FSM=IDLE; cmd_valid edge register=0.
- Command acceptance:
  - A new word is taken only on the rising edge of cmd_valid, registered, in state IDLE.
  - cmd_ack is pulsed the same cycle the word is latched, and the FSM moves to DECODE.
  - A cmd_valid rising edge seen outside IDLE is remembered (one-deep) and taken on return to IDLE; it is never dropped.
- Opcodes (payload p = cmd_data[31:8]); unknown opcodes are acked and ignored:
  - 0x10 WR_FTW_LO: shadow_ftw[23:0] <= p.
  - 0x11 WR_FTW_HI: shadow_ftw[31:24] <= p[7:0].
  - 0x12 WR_PHASE: shadow_pow[15:0] <= p[15:0].
  - 0x13 WR_CTRL: shadow_wave <= p[1:0] (0 SAW, 1 TRI, 2 SQR, 3 DC); shadow_en <= p[8].
  - 0x14 APPLY: active registers <= shadow registers in the DECODE cycle. If p[0]=1, the accumulator is also cleared that cycle; the clear wins over the increment.
  - 0x15 RD_FTW: response = active_ftw[23:0].
  - 0x16 RD_STATUS: response = {active_ftw[31:24], 8'h00, 4'h0, pending, active_en, active_wave}. pending = shadow differs from active.
- FSM:
  - IDLE -> DECODE on an accepted word.
  - DECODE -> IDLE for write, APPLY and unknown opcodes.
  - DECODE -> RESP for reads.
  - RESP: drives rsp_wr_en=1 and rsp_data in the first cycle rsp_free=1 (possibly the cycle after DECODE), then -> IDLE. Waits indefinitely while rsp_free=0; rsp_data is held stable meanwhile.
- Core:
  - When active_en=1: acc <= acc + active_ftw every cycle, modulo 2^32. sync_pulse=1 in the cycle following a carry out.
  - When active_en=0: acc holds, sync_pulse=0, dac_valid=0.
- Sample generation: phase = acc[31:16] + active_pow (16-bit wrap).
  - SAW: phase[15 -: DAC_W].
  - TRI: phase[15] ? ~phase[14 -: DAC_W] : phase[14 -: DAC_W].
  - SQR: phase[15] ? all ones : 0.
  - DC: active_pow[15 -: DAC_W].
  - dac_data is registered: it reflects the accumulator value of the previous cycle (latency 1 from acc to output).
  - dac_data keeps updating from the held phase when disabled.
- Writes to the shadow registers never disturb the running output until APPLY.
- A reset asserted mid-RESP aborts the response; no rsp_wr_en is issued.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, acc 0, no sync_pulse.
- Write FTW_LO p=0x000000, FTW_HI p=0x40, CTRL p=0x100 (SAW, en), then APPLY p=0:
  - sync_pulse every 4 cycles.
  - dac_data sequence 0x000, 0x400, 0x800, 0xC00 repeating.
  - cmd_ack one pulse per word.
- With rsp_free=0, send RD_FTW after ftw=0x12345678 is applied:
  - no rsp_wr_en while rsp_free=0.
  - a second word arriving meanwhile is not acked.
  - raise rsp_free -> rsp_data=0x345678 for one rsp_wr_en pulse, then the second word is acked.
- Write CTRL SQR without APPLY -> output unchanged, RD_STATUS pending=1. After APPLY -> pending=0, dac_data toggles 0x000/0xFFF.
- APPLY p=1 while running at ftw=0x40000000 -> acc=0 the next cycle (clear beats increment), dac_data=0x000 one cycle later.
- Opcode 0x03 and 0x7F -> acked, no state change, no response.
